// File: rtl/gp_counter_core_if.sv
// Configuration, status and pin bundle between the register block and the counter core.
// Latency: none, wires only.
// Backpressure: none; levels are sampled every clock by the core.
//
// master : register block / environment side (drives config fields, ext inputs)
// slave  : counter core side (consumes config, returns counter/capture/status/pin)
interface gp_counter_core_if #(
    parameter int CNT_W  = 10,
    parameter int NUM_IN = 16
);
    logic [1:0]        mode_i;
    logic [CNT_W-1:0]  duty_cycle_i;
    logic [1:0]        frequency_selection_i;
    logic [3:0]        input_selection_i;
    logic [1:0]        trigger_selection_i;
    logic              out_function_i;
    logic [1:0]        capture_selection_i;
    logic [CNT_W-1:0]  target_value_i;
    logic              clear_i;
    logic              sw_trigger_i;
    logic [NUM_IN-1:0] ext_in_i;
    logic [CNT_W-1:0]  counter_o;
    logic [CNT_W-1:0]  captured_value_o;
    logic              tm_running_o;
    logic              out_o;

    modport master (
        output mode_i, duty_cycle_i, frequency_selection_i, input_selection_i,
               trigger_selection_i, out_function_i, capture_selection_i,
               target_value_i, clear_i, sw_trigger_i, ext_in_i,
        input  counter_o, captured_value_o, tm_running_o, out_o
    );

    modport slave (
        input  mode_i, duty_cycle_i, frequency_selection_i, input_selection_i,
               trigger_selection_i, out_function_i, capture_selection_i,
               target_value_i, clear_i, sw_trigger_i, ext_in_i,
        output counter_o, captured_value_o, tm_running_o, out_o
    );
endinterface

// File: rtl/gp_counter_core.sv
// General-purpose counter execution core: PWM, edge counter, one-shot timer, edge capture.
// Latency: ext pin edge acts on the count 3 clocks later (5 with the glitch filter); outputs registered.
// Backpressure: none; config levels are consumed every clock.
//
// Ports: clk_i / rstn_i (async active-low reset); bus (gp_counter_core_if.slave) carries the
// decoded config fields, the ext_in_i pins and the counter_o / captured_value_o /
// tm_running_o / out_o readback.
// Optional build macro GP_CNT_GLITCH_FILTER_EN: 3-sample stable filter on the selected input.
module gp_counter_core #(
    parameter int CNT_W  = 10,
    parameter int NUM_IN = 16
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    gp_counter_core_if.slave bus
);

    typedef enum logic {
        TM_IDLE = 1'b0,
        TM_RUN  = 1'b1
    } tm_state_t;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_PWM  = 2'b01;
    localparam logic [1:0] MODE_EDGE = 2'b10;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Input path: 2-flop synchroniser, select mux, optional filter, edge detect
    // ------------------------------------------------------------------
    logic [NUM_IN-1:0] sync1_q;
    logic [NUM_IN-1:0] sync2_q;
    logic              sel_lvl;
    logic              filt_lvl;
    logic              lvl_q;       // previous filtered level, doubles as edge-detect flop
    logic              in_rise;
    logic              in_fall;

    assign sel_lvl = sync2_q[bus.input_selection_i];

`ifdef GP_CNT_GLITCH_FILTER_EN
    // hist_q[0] is the previous sample, hist_q[1] the one before. The level only
    // moves when the current sample and both history samples agree.
    logic [1:0] hist_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            hist_q <= 2'b00;
        end else begin
            hist_q <= {hist_q[0], sel_lvl};
        end
    end

    assign filt_lvl = (sel_lvl == hist_q[0] && hist_q[0] == hist_q[1]) ? sel_lvl : lvl_q;
`else
    assign filt_lvl = sel_lvl;
`endif

    // Edges are taken from the combinational filtered level so the count lands on the
    // same clock that lvl_q picks the new level up.
    assign in_rise =  filt_lvl & ~lvl_q;
    assign in_fall = ~filt_lvl &  lvl_q;

    logic       sw_q;
    logic [1:0] mode_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            lvl_q   <= 1'b0;
            sw_q    <= 1'b0;
            mode_q  <= MODE_OFF;
        end else begin
            sync1_q <= bus.ext_in_i;
            sync2_q <= sync1_q;
            lvl_q   <= filt_lvl;
            sw_q    <= bus.sw_trigger_i;
            mode_q  <= bus.mode_i;
        end
    end

    // ------------------------------------------------------------------
    // Decode of events used by the mode logic
    // ------------------------------------------------------------------
    logic       sw_rise;
    logic       mode_chg;
    logic       cap_evt;
    logic       tm_trig;
    logic       tick;
    logic [2:0] psc_q;
    logic [2:0] psc_last;

    assign sw_rise  = bus.sw_trigger_i & ~sw_q;
    assign mode_chg = (bus.mode_i != mode_q);

    always_comb begin
        psc_last = 3'd0;
        case (bus.frequency_selection_i)
            2'b00:   psc_last = 3'd0;
            2'b01:   psc_last = 3'd1;
            2'b10:   psc_last = 3'd3;
            default: psc_last = 3'd7;
        endcase
    end

    assign tick = (psc_q == psc_last);

    assign cap_evt = (bus.capture_selection_i[0] & in_rise) |
                     (bus.capture_selection_i[1] & in_fall);

    // Software trigger starts the timer regardless of the input-edge selection.
    assign tm_trig = sw_rise |
                     (bus.trigger_selection_i[0] & in_rise) |
                     (bus.trigger_selection_i[1] & in_fall);

    // ------------------------------------------------------------------
    // Mode operation: state register + next-state logic
    // ------------------------------------------------------------------
    tm_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cap_q, cap_d;
    logic             out_q, out_d;
    logic [2:0]       psc_d;
    logic             match;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= TM_IDLE;
            cnt_q   <= '0;
            cap_q   <= '0;
            out_q   <= 1'b0;
            psc_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            out_q   <= out_d;
            psc_q   <= psc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        out_d   = out_q;
        psc_d   = tick ? 3'd0 : psc_q + 3'd1;
        match   = 1'b0;

        if (bus.clear_i || mode_chg) begin
            // Clear and mode change both wipe the live state; the capture register survives.
            state_d = TM_IDLE;
            cnt_d   = '0;
            out_d   = 1'b0;
            psc_d   = 3'd0;
        end else begin
            // Capture reads the count before this cycle's update.
            if (bus.mode_i != MODE_OFF && cap_evt) begin
                cap_d = cnt_q;
            end

            case (bus.mode_i)
                MODE_OFF: begin
                    state_d = TM_IDLE;
                    cnt_d   = '0;
                    out_d   = 1'b0;
                end
                MODE_PWM: begin
                    state_d = TM_IDLE;
                    out_d   = (cnt_q < bus.duty_cycle_i);
                    if (tick) begin
                        cnt_d = cnt_q + CNT_ONE;  // free-running, wraps at all-ones
                    end
                end
                MODE_EDGE: begin
                    state_d = TM_IDLE;
                    if (in_rise) begin
                        if (cnt_q == bus.target_value_i) begin
                            cnt_d = '0;
                            match = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                end
                default: begin
                    if (state_q == TM_IDLE) begin
                        // Count holds (target after a match) until the next start.
                        if (tm_trig) begin
                            state_d = TM_RUN;
                            cnt_d   = '0;
                            psc_d   = 3'd0;
                        end
                    end else if (tick) begin
                        // Equality compare: a target below the count is reached after wrap.
                        if (cnt_q == bus.target_value_i) begin
                            match   = 1'b1;
                            state_d = TM_IDLE;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                end
            endcase

            // Edge-counter and timer share the match-driven pin function.
            if (bus.mode_i[1]) begin
                out_d = bus.out_function_i ? (out_q ^ match) : match;
            end
        end
    end

    assign bus.counter_o        = cnt_q;
    assign bus.captured_value_o = cap_q;
    assign bus.tm_running_o     = (state_q == TM_RUN);
    assign bus.out_o            = out_q;

endmodule
